mult_seq_ctrl: RTL and testbench



---
 rtl/mult_pkg.sv | 47 ++++
 rtl/accum16.sv | 45 ++++
 rtl/mult_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_mult_seq_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mult_pkg
//  Description : Shared widths, state encoding and shift codes for the
//                sequencing/accumulation stage of the 8x8 sequential
//                multiplier.
//  Revision    : 1.0 - initial release
// ============================================================================
package mult_pkg;

    // Fixed datapath widths
    localparam int OP_W   = 8;
    localparam int NIB_W  = 4;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 2;

    // Index of the final partial-product step
    localparam logic [CNT_W-1:0] LAST_STEP = 2'd3;

    // Controller state encoding (2'b11 is unreachable and folds to IDLE)
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    // Partial-product shifter codes; 2'b11 is never driven
    localparam logic [1:0] SHIFT_0 = 2'b00;
    localparam logic [1:0] SHIFT_4 = 2'b01;
    localparam logic [1:0] SHIFT_8 = 2'b10;

    // Shift weight for a step: lo*lo -> 0, the two cross terms -> 4,
    // hi*hi -> 8.
    function automatic logic [1:0] step_shift(input logic [CNT_W-1:0] step);
        logic [1:0] code;
        case (step)
            2'd0:    code = SHIFT_0;
            2'd1:    code = SHIFT_4;
            2'd2:    code = SHIFT_4;
            2'd3:    code = SHIFT_8;
            default: code = SHIFT_0;
        endcase
        return code;
    endfunction

endpackage : mult_pkg
`default_nettype wire

// File: rtl/accum16.sv
`default_nettype none
// ============================================================================
//  Module      : accum16
//  Description : 16-bit accumulator register. Asynchronous reset,
//                synchronous clear (priority) and add-enable. The carry out
//                of the add is dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum16
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset_a,
    input  logic              i_clr,
    input  logic              i_add_en,
    input  logic [PROD_W-1:0] i_addend,
    output logic [PROD_W-1:0] o_acc
);

    logic [PROD_W-1:0] acc_q;
    logic [PROD_W-1:0] acc_d;

    // Next accumulator value: clear wins over add, otherwise hold
    always_comb begin
        acc_d = acc_q;
        if (i_clr) begin
            acc_d = '0;
        end else if (i_add_en) begin
            acc_d = acc_q + i_addend;
        end
    end

    // Accumulator storage with asynchronous reset
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign o_acc = acc_q;

endmodule : accum16
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mult_seq_ctrl
//  Description : Sequencer for the 8x8 sequential multiplier. Latches the
//                operands on an accepted start, walks the four nibble-pair
//                products (one per cycle), drives the nibble selects and the
//                shifter code, accumulates the returned shifted partial
//                products and pulses done for one cycle with the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_seq_ctrl
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset_a,
    input  logic              start,
    input  logic [OP_W-1:0]   dataa,
    input  logic [OP_W-1:0]   datab,
    input  logic [PROD_W-1:0] shift_out,
    output logic [NIB_W-1:0]  a_nib,
    output logic [NIB_W-1:0]  b_nib,
    output logic [1:0]        shift_cntrl,
    output logic [PROD_W-1:0] product,
    output logic              busy,
    output logic              done
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;
    logic [OP_W-1:0]    opa_q;
    logic [OP_W-1:0]    opa_d;
    logic [OP_W-1:0]    opb_q;
    logic [OP_W-1:0]    opb_d;

    logic               w_accept;
    logic               w_in_calc;

    // A start is only honoured in IDLE; anything else is dropped, not queued
    assign w_accept  = (state_q == IDLE) && start;
    assign w_in_calc = (state_q == CALC);

    // Next-state, step counter and operand capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    opa_d   = dataa;
                    opb_d   = datab;
                end
            end
            CALC: begin
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Control registers with asynchronous reset
    always_ff @(posedge clk or posedge reset_a) begin
        if (reset_a) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
        end
    end

    // Step decode: cnt[1] picks the dataa nibble, cnt[0] the datab nibble;
    // everything is parked at zero outside CALC.
    always_comb begin
        a_nib       = '0;
        b_nib       = '0;
        shift_cntrl = SHIFT_0;
        if (w_in_calc) begin
            a_nib       = cnt_q[1] ? opa_q[OP_W-1:NIB_W] : opa_q[NIB_W-1:0];
            b_nib       = cnt_q[0] ? opb_q[OP_W-1:NIB_W] : opb_q[NIB_W-1:0];
            shift_cntrl = step_shift(cnt_q);
        end
    end

    // ------------------------------------------------------------------
    // Accumulator: cleared on accept, adds the external shifted partial
    // product on every CALC cycle. shift_out is combinational from this
    // cycle's selects, so no pipeline stage sits on it.
    // ------------------------------------------------------------------
    accum16 u_accum (
        .clk      (clk),
        .reset_a  (reset_a),
        .i_clr    (w_accept),
        .i_add_en (w_in_calc),
        .i_addend (shift_out),
        .o_acc    (product)
    );

    assign busy = w_in_calc;
    assign done = (state_q == DONE);

endmodule : mult_seq_ctrl
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_seq_ctrl
//  Description : Directed self-checking bench for mult_seq_ctrl. A
//                behavioural 4x4 multiplier and shifter close the loop on
//                the nibble/shift outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_seq_ctrl;

    logic        clk;
    logic        reset_a;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;
    logic [15:0] shift_out;
    logic [3:0]  a_nib;
    logic [3:0]  b_nib;
    logic [1:0]  shift_cntrl;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    mult_seq_ctrl dut (
        .clk         (clk),
        .reset_a     (reset_a),
        .start       (start),
        .dataa       (dataa),
        .datab       (datab),
        .shift_out   (shift_out),
        .a_nib       (a_nib),
        .b_nib       (b_nib),
        .shift_cntrl (shift_cntrl),
        .product     (product),
        .busy        (busy),
        .done        (done)
    );

    // External 4x4 multiplier + shifter
    logic [7:0] nib_prod;
    assign nib_prod = {4'd0, a_nib} * {4'd0, b_nib};

    always_comb begin
        shift_out = 16'd0;
        case (shift_cntrl)
            2'b00:   shift_out = {8'd0, nib_prod};
            2'b01:   shift_out = {4'd0, nib_prod, 4'd0};
            2'b10:   shift_out = {nib_prod, 8'd0};
            default: shift_out = 16'hDEAD;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag, input logic [15:0] exp_prod);
        chk({tag, ".busy"},  {15'd0, busy}, 16'd0);
        chk({tag, ".done"},  {15'd0, done}, 16'd0);
        chk({tag, ".a_nib"}, {12'd0, a_nib}, 16'd0);
        chk({tag, ".b_nib"}, {12'd0, b_nib}, 16'd0);
        chk({tag, ".shift"}, {14'd0, shift_cntrl}, 16'd0);
        chk({tag, ".prod"},  product, exp_prod);
    endtask

    // One full multiply from a single start pulse, checking every cycle.
    // Operand inputs are scrambled during CALC to prove they were latched.
    task automatic do_mult(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] exp);
        logic [1:0] exp_sh [4];
        logic [3:0] ea;
        logic [3:0] eb;
        exp_sh = '{2'b00, 2'b01, 2'b01, 2'b10};
        dataa = a;
        datab = b;
        start = 1'b1;
        tick();                      // edge N sampled start -> cycle N+1
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            dataa = ~a;
            datab = a ^ b ^ 8'h5A;
            ea = (k >= 2)       ? a[7:4] : a[3:0];
            eb = (k % 2 == 1)   ? b[7:4] : b[3:0];
            chk({tag, ".busy"},  {15'd0, busy}, 16'd1);
            chk({tag, ".done"},  {15'd0, done}, 16'd0);
            chk({tag, ".a_nib"}, {12'd0, a_nib}, {12'd0, ea});
            chk({tag, ".b_nib"}, {12'd0, b_nib}, {12'd0, eb});
            chk({tag, ".shift"}, {14'd0, shift_cntrl}, {14'd0, exp_sh[k]});
            tick();
        end
        // cycle N+5
        chk({tag, ".done5"}, {15'd0, done}, 16'd1);
        chk({tag, ".busy5"}, {15'd0, busy}, 16'd0);
        chk({tag, ".prod5"}, product, exp);
        tick();
        // cycle N+6: idle, product held
        chk_idle_outs({tag, ".after"}, exp);
    endtask

    initial begin
        reset_a = 1'b1;
        start   = 1'b0;
        dataa   = 8'h00;
        datab   = 8'h00;
        repeat (3) tick();
        chk_idle_outs("reset", 16'h0000);
        reset_a = 1'b0;
        tick();
        chk_idle_outs("post_reset", 16'h0000);

        // Ten idle cycles with wandering operands and no start
        for (int i = 0; i < 10; i++) begin
            dataa = 8'(i * 37 + 3);
            datab = 8'(i * 91 + 7);
            tick();
            chk_idle_outs("idle", 16'h0000);
        end

        do_mult("m12x34", 8'h12, 8'h34, 16'h03A8);
        do_mult("mFFxFF", 8'hFF, 8'hFF, 16'hFE01);
        do_mult("m00xAB", 8'h00, 8'hAB, 16'h0000);
        do_mult("m80x02", 8'h80, 8'h02, 16'h0100);

        // start pulsed during CALC (cycle N+2) and DONE (cycle N+5): ignored
        dataa = 8'h23;
        datab = 8'h45;
        start = 1'b1;
        tick();                      // N+1
        start = 1'b0;
        chk("ign.busy1", {15'd0, busy}, 16'd1);
        tick();                      // N+2
        start = 1'b1;
        dataa = 8'h99;
        datab = 8'h99;
        tick();                      // N+3
        start = 1'b0;
        chk("ign.busy3", {15'd0, busy}, 16'd1);
        chk("ign.done3", {15'd0, done}, 16'd0);
        tick();                      // N+4
        chk("ign.busy4", {15'd0, busy}, 16'd1);
        tick();                      // N+5
        chk("ign.done5", {15'd0, done}, 16'd1);
        chk("ign.prod5", product, 16'h096F);
        start = 1'b1;
        tick();                      // N+6
        start = 1'b0;
        chk_idle_outs("ign.n6", 16'h096F);
        tick();                      // N+7
        chk_idle_outs("ign.n7", 16'h096F);
        tick();
        chk_idle_outs("ign.n8", 16'h096F);

        // start held high: back-to-back multiplies every 6 cycles
        dataa = 8'h0F;
        datab = 8'h0F;
        start = 1'b1;
        tick();                      // N+1
        dataa = 8'hF0;
        datab = 8'h10;
        chk("b2b.busy1", {15'd0, busy}, 16'd1);
        repeat (4) tick();           // N+5
        chk("b2b.done5", {15'd0, done}, 16'd1);
        chk("b2b.prod5", product, 16'h00E1);
        tick();                      // N+6 idle, accept on this edge
        chk("b2b.busy6", {15'd0, busy}, 16'd0);
        chk("b2b.done6", {15'd0, done}, 16'd0);
        chk("b2b.prod6", product, 16'h00E1);
        tick();                      // N+7
        chk("b2b.busy7", {15'd0, busy}, 16'd1);
        repeat (3) tick();           // N+10
        chk("b2b.done10", {15'd0, done}, 16'd0);
        tick();                      // N+11
        start = 1'b0;
        chk("b2b.done11", {15'd0, done}, 16'd1);
        chk("b2b.prod11", product, 16'h0F00);
        tick();
        chk_idle_outs("b2b.end", 16'h0F00);

        // Asynchronous reset in the middle of CALC (cycle N+3)
        dataa = 8'h12;
        datab = 8'h34;
        start = 1'b1;
        tick();                      // N+1
        start = 1'b0;
        tick();                      // N+2
        tick();                      // N+3
        chk("rst.busy_pre", {15'd0, busy}, 16'd1);
        reset_a = 1'b1;
        #1;
        chk_idle_outs("rst.async", 16'h0000);
        #2;
        reset_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk_idle_outs("rst.after", 16'h0000);
        end

        do_mult("m05x07", 8'h05, 8'h07, 16'h0023);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_seq_ctrl
`default_nettype wire
